// File: rtl/riscv_pkg.sv
// Shared RV32 control-flow decode types: opcodes, branch funct3 codes, E-stage record.
// Pure declarations; no timing or flow control of its own.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_JAL    = 2'd2,
    CLS_JALR   = 2'd3
  } cf_class_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    cf_class_e   op;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator; purely combinational, no state, no flow control.
// Unused funct3 codes (010/011) evaluate to not-taken.
module branch_cmp
  import riscv_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  Funct3,
  output logic        cond
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (SrcA == SrcB);
  assign lt_s = ($signed(SrcA) < $signed(SrcB));
  assign lt_u = (SrcA < SrcB);

  always_comb begin
    cond = 1'b0;
    case (Funct3)
      BEQ:     cond = eq;
      BNE:     cond = ~eq;
      BLT:     cond = lt_s;
      BGE:     cond = ~lt_s;
      BLTU:    cond = lt_u;
      BGEU:    cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/JAL/JALR resolver with ID/EX register; outputs one cycle after D sampling.
// No backpressure: FlushE or its own redirect loads a bubble, otherwise E captures D every cycle.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic            FlushE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            FlushD,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            LinkE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            MisalignE
);

  idex_t       d_nxt;
  idex_t       e_q;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cond;
  logic        taken;
  logic [31:0] pc_sum;
  logic [31:0] reg_sum;

  // D-side decode: classify and extract the sign-extended immediate for that class
  always_comb begin
    d_nxt         = '0;
    d_nxt.valid   = ValidD;
    d_nxt.pc      = PCD;
    d_nxt.pcplus4 = PCPlus4D;
    d_nxt.rd1     = RD1D;
    d_nxt.rd2     = RD2D;
    d_nxt.funct3  = InstrD[14:12];
    d_nxt.rs1     = InstrD[19:15];
    d_nxt.rs2     = InstrD[24:20];
    d_nxt.rd      = InstrD[11:7];
    d_nxt.op      = CLS_NONE;
    d_nxt.imm     = '0;
    case (InstrD[6:0])
      OP_BRANCH: begin
        d_nxt.op  = CLS_BRANCH;
        d_nxt.imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        d_nxt.op  = CLS_JAL;
        d_nxt.imm = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_JALR: begin
        d_nxt.op  = CLS_JALR;
        d_nxt.imm = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      default: begin
        d_nxt.op  = CLS_NONE;
        d_nxt.imm = '0;
      end
    endcase
  end

  // The cycle after a redirect the D entry is wrong-path, so it is dropped like a flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q <= '0;
    end else if (FlushE || PCSrcE) begin
      e_q <= '0;
    end else begin
      e_q <= d_nxt;
    end
  end

  always_comb begin
    src_a = e_q.rd1;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = e_q.rd1;
    endcase
  end

  always_comb begin
    src_b = e_q.rd2;
    case (ForwardBE)
      2'b01:   src_b = ResultW;
      2'b10:   src_b = ALUResultM;
      default: src_b = e_q.rd2;
    endcase
  end

  branch_cmp u_cmp (
    .SrcA   (src_a),
    .SrcB   (src_b),
    .Funct3 (e_q.funct3),
    .cond   (cond)
  );

  assign pc_sum  = e_q.pc + e_q.imm;
  assign reg_sum = src_a + e_q.imm;

  always_comb begin
    taken     = 1'b0;
    PCTargetE = '0;
    if (e_q.valid) begin
      case (e_q.op)
        CLS_BRANCH: begin
          taken     = cond;
          PCTargetE = pc_sum;
        end
        CLS_JAL: begin
          taken     = 1'b1;
          PCTargetE = pc_sum;
        end
        CLS_JALR: begin
          taken     = 1'b1;
          PCTargetE = {reg_sum[31:1], 1'b0};
        end
        default: begin
          taken     = 1'b0;
          PCTargetE = '0;
        end
      endcase
    end
  end

  assign PCSrcE    = taken;
  assign FlushD    = taken;
  assign MisalignE = taken & PCTargetE[1];
  assign LinkE     = e_q.valid & ((e_q.op == CLS_JAL) | (e_q.op == CLS_JALR));
  assign PCPlus4E  = e_q.valid ? e_q.pcplus4 : '0;
  assign Rs1E      = e_q.rs1;
  assign Rs2E      = e_q.rs2;
  assign RdE       = e_q.rd;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed redirect, link and flush expectations.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic        FlushE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic [31:0] ALUResultM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        FlushD;
  logic [31:0] PCPlus4E;
  logic        LinkE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        MisalignE;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_resolve #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .ALUResultM (ALUResultM),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .FlushD     (FlushD),
    .PCPlus4E   (PCPlus4E),
    .LinkE      (LinkE),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .MisalignE  (MisalignE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_d(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                         input logic [31:0] rd1, input logic [31:0] rd2);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    ValidD   = valid;
    RD1D     = rd1;
    RD2D     = rd2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    FlushE     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    ResultW    = 32'h0;
    ALUResultM = 32'h0;
    drive_d(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset held two cycles, then released with a bubble in D
    tick();
    tick();
    check("rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("rst_target", PCTargetE, 32'h0);
    reset = 1'b1;
    tick();
    check("idle_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("idle_target", PCTargetE, 32'h0);
    check("idle_flushd", {31'b0, FlushD}, 32'h0);
    check("idle_link", {31'b0, LinkE}, 32'h0);
    check("idle_pcp4", PCPlus4E, 32'h0);
    check("idle_mis", {31'b0, MisalignE}, 32'h0);
    check("idle_regs", {17'b0, Rs1E, Rs2E, RdE}, 32'h0);

    // BEQ x1,x2,+16 at 0x100 with equal operands
    drive_d(32'h00208863, 32'h100, 1'b1, 32'd5, 32'd5);
    tick();
    check("beq_pcsrc", {31'b0, PCSrcE}, 32'h1);
    check("beq_target", PCTargetE, 32'h110);
    check("beq_flushd", {31'b0, FlushD}, 32'h1);
    check("beq_link", {31'b0, LinkE}, 32'h0);
    check("beq_rs", {22'b0, Rs1E, Rs2E}, {22'b0, 5'd1, 5'd2});
    // Wrong-path valid instruction in D must be squashed
    drive_d(32'h00208863, 32'h104, 1'b1, 32'd5, 32'd5);
    tick();
    check("beq_squash_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("beq_squash_rs1", {27'b0, Rs1E}, 32'h0);

    // BLT x1,x2,+8: -1 < 1 signed, taken
    drive_d(32'h0020C463, 32'h200, 1'b1, 32'hFFFFFFFF, 32'd1);
    tick();
    check("blt_pcsrc", {31'b0, PCSrcE}, 32'h1);
    check("blt_target", PCTargetE, 32'h208);
    drive_d(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    // BLTU x1,x2,+8: 0xFFFFFFFF < 1 unsigned is false
    drive_d(32'h0020E463, 32'h208, 1'b1, 32'hFFFFFFFF, 32'd1);
    tick();
    check("bltu_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("bltu_flushd", {31'b0, FlushD}, 32'h0);

    // JALR x1,3(x5) with rs1 forwarded from the memory stage
    drive_d(32'h003280E7, 32'h300, 1'b1, 32'h1234, 32'h0);
    ForwardAE  = 2'b10;
    ALUResultM = 32'h2000;
    tick();
    check("jalr_pcsrc", {31'b0, PCSrcE}, 32'h1);
    check("jalr_target", PCTargetE, 32'h2002);
    check("jalr_mis", {31'b0, MisalignE}, 32'h1);
    check("jalr_link", {31'b0, LinkE}, 32'h1);
    check("jalr_pcp4", PCPlus4E, 32'h304);
    check("jalr_rd", {27'b0, RdE}, 32'd1);
    drive_d(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    ForwardAE = 2'b00;
    check("post_jalr_pcsrc", {31'b0, PCSrcE}, 32'h0);

    // JAL x1,-8 at address 0 wraps
    drive_d(32'hFF9FF0EF, 32'h0, 1'b1, 32'h0, 32'h0);
    tick();
    check("jal_pcsrc", {31'b0, PCSrcE}, 32'h1);
    check("jal_target", PCTargetE, 32'hFFFFFFF8);
    check("jal_mis", {31'b0, MisalignE}, 32'h0);
    check("jal_link", {31'b0, LinkE}, 32'h1);
    check("jal_pcp4", PCPlus4E, 32'h4);
    drive_d(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();

    // Taken BNE blocked by FlushE at the load edge
    drive_d(32'h00209863, 32'h400, 1'b1, 32'd1, 32'd2);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    check("flushe_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("flushe_link", {31'b0, LinkE}, 32'h0);

    // Non-control-flow ADD x3,x1,x2: valid but never redirects
    drive_d(32'h002081B3, 32'h500, 1'b1, 32'd7, 32'd9);
    tick();
    check("add_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("add_target", PCTargetE, 32'h0);
    check("add_link", {31'b0, LinkE}, 32'h0);
    check("add_regs", {17'b0, Rs1E, Rs2E, RdE}, {17'b0, 5'd1, 5'd2, 5'd3});
    check("add_pcp4", PCPlus4E, 32'h504);

    // Taken BNE blocked by reset at the load edge: everything clears
    drive_d(32'h00209863, 32'h600, 1'b1, 32'd1, 32'd2);
    reset = 1'b0;
    tick();
    check("rstmid_pcsrc", {31'b0, PCSrcE}, 32'h0);
    check("rstmid_target", PCTargetE, 32'h0);
    check("rstmid_regs", {17'b0, Rs1E, Rs2E, RdE}, 32'h0);
    check("rstmid_pcp4", PCPlus4E, 32'h0);
    reset = 1'b1;
    drive_d(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
